// File: rtl/bjp_stat_rd.sv
// Branch/jump prediction statistics bank: per-class event and mispredict counters,
// a single-counter host read port and an end-of-run dump stream.
// Define BJP_STAT_SAT_EN for saturating counters with a sticky overflow flag.

module bjp_stat_rd #(
    parameter int CNT_W   = 32,
    parameter int NUM_CLS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt_vld,
    input  logic [3:0]       evt_cls,
    input  logic             evt_miss,
    input  logic             clr,
    input  logic             core_end,
    input  logic             rd_req_vld,
    output logic             rd_req_rdy,
    input  logic [4:0]       rd_req_idx,
    output logic             rd_rsp_vld,
    input  logic             rd_rsp_rdy,
    output logic [CNT_W-1:0] rd_rsp_data,
    output logic             rd_rsp_err,
    output logic             dump_vld,
    input  logic             dump_rdy,
    output logic [CNT_W-1:0] dump_data,
    output logic             dump_last,
    output logic             dump_done
);

    localparam int NUM_WORDS = 2 * NUM_CLS;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DUMP,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] dump_idx_q, dump_idx_d;
    logic [CNT_W-1:0] tot_q  [NUM_CLS];
    logic [CNT_W-1:0] tot_d  [NUM_CLS];
    logic [CNT_W-1:0] miss_q [NUM_CLS];
    logic [CNT_W-1:0] miss_d [NUM_CLS];
`ifdef BJP_STAT_SAT_EN
    logic [NUM_CLS-1:0] tot_ovf_q, tot_ovf_d;
    logic [NUM_CLS-1:0] miss_ovf_q, miss_ovf_d;
`endif

    logic             rd_rsp_vld_q, rd_rsp_vld_d;
    logic [CNT_W-1:0] rd_rsp_data_q, rd_rsp_data_d;
    logic             rd_rsp_err_q, rd_rsp_err_d;
    logic [CNT_W-1:0] rd_sel_data;
    logic             rd_sel_err;

    logic             dump_vld_q, dump_vld_d;
    logic [CNT_W-1:0] dump_data_q, dump_data_d;
    logic             dump_last_q, dump_last_d;
    logic             dump_done_q, dump_done_d;
    logic [CNT_W-1:0] dump_word;

    logic evt_hit;

    assign evt_hit = evt_vld && (int'(evt_cls) < NUM_CLS);

    // Counters only move while IDLE so the dump always sees a frozen snapshot.
    always_comb begin
        tot_d  = tot_q;
        miss_d = miss_q;
`ifdef BJP_STAT_SAT_EN
        tot_ovf_d  = tot_ovf_q;
        miss_ovf_d = miss_ovf_q;
`endif
        if (state_q == ST_IDLE) begin
            if (clr) begin
                for (int c = 0; c < NUM_CLS; c++) begin
                    tot_d[c]  = '0;
                    miss_d[c] = '0;
                end
`ifdef BJP_STAT_SAT_EN
                tot_ovf_d  = '0;
                miss_ovf_d = '0;
`endif
            end else if (evt_hit) begin
                for (int c = 0; c < NUM_CLS; c++) begin
                    if (int'(evt_cls) == c) begin
`ifdef BJP_STAT_SAT_EN
                        if (&tot_q[c]) tot_ovf_d[c] = 1'b1;
                        else           tot_d[c]     = tot_q[c] + CNT_W'(1);
                        if (evt_miss) begin
                            if (&miss_q[c]) miss_ovf_d[c] = 1'b1;
                            else            miss_d[c]     = miss_q[c] + CNT_W'(1);
                        end
`else
                        tot_d[c] = tot_q[c] + CNT_W'(1);
                        if (evt_miss) miss_d[c] = miss_q[c] + CNT_W'(1);
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        rd_sel_data = '0;
        rd_sel_err  = 1'b1;
        for (int c = 0; c < NUM_CLS; c++) begin
            if (rd_req_idx == 5'(c)) begin
                rd_sel_data = tot_q[c];
                rd_sel_err  = 1'b0;
`ifdef BJP_STAT_SAT_EN
                if (tot_ovf_q[c]) rd_sel_data[CNT_W-1] = 1'b1;
`endif
            end
            if (rd_req_idx == 5'(16 + c)) begin
                rd_sel_data = miss_q[c];
                rd_sel_err  = 1'b0;
`ifdef BJP_STAT_SAT_EN
                if (miss_ovf_q[c]) rd_sel_data[CNT_W-1] = 1'b1;
`endif
            end
        end
    end

    assign rd_req_rdy = !rd_rsp_vld_q;

    always_comb begin
        rd_rsp_vld_d  = rd_rsp_vld_q;
        rd_rsp_data_d = rd_rsp_data_q;
        rd_rsp_err_d  = rd_rsp_err_q;
        if (rd_rsp_vld_q && rd_rsp_rdy) begin
            rd_rsp_vld_d  = 1'b0;
            rd_rsp_data_d = '0;
            rd_rsp_err_d  = 1'b0;
        end
        if (rd_req_vld && rd_req_rdy) begin
            rd_rsp_vld_d  = 1'b1;
            rd_rsp_data_d = rd_sel_data;
            rd_rsp_err_d  = rd_sel_err;
        end
    end

    always_comb begin
        state_d    = state_q;
        dump_idx_d = dump_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (core_end) begin
                    state_d    = ST_DUMP;
                    dump_idx_d = '0;
                end
            end
            ST_DUMP: begin
                if (dump_vld_q && dump_rdy) begin
                    if (dump_idx_q == LAST_IDX) state_d    = ST_DONE;
                    else                        dump_idx_d = dump_idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (!core_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Words come from next-state counters so an event in the core_end cycle is included.
    always_comb begin
        dump_word = '0;
        for (int c = 0; c < NUM_CLS; c++) begin
            if (dump_idx_d == IDX_W'(c))           dump_word = tot_d[c];
            if (dump_idx_d == IDX_W'(NUM_CLS + c)) dump_word = miss_d[c];
        end
    end

    always_comb begin
        dump_vld_d  = (state_d == ST_DUMP);
        dump_last_d = dump_vld_d && (dump_idx_d == LAST_IDX);
        dump_data_d = dump_vld_d ? dump_word : '0;
        dump_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dump_idx_q    <= '0;
            for (int c = 0; c < NUM_CLS; c++) begin
                tot_q[c]  <= '0;
                miss_q[c] <= '0;
            end
`ifdef BJP_STAT_SAT_EN
            tot_ovf_q     <= '0;
            miss_ovf_q    <= '0;
`endif
            rd_rsp_vld_q  <= 1'b0;
            rd_rsp_data_q <= '0;
            rd_rsp_err_q  <= 1'b0;
            dump_vld_q    <= 1'b0;
            dump_data_q   <= '0;
            dump_last_q   <= 1'b0;
            dump_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            dump_idx_q    <= dump_idx_d;
            for (int c = 0; c < NUM_CLS; c++) begin
                tot_q[c]  <= tot_d[c];
                miss_q[c] <= miss_d[c];
            end
`ifdef BJP_STAT_SAT_EN
            tot_ovf_q     <= tot_ovf_d;
            miss_ovf_q    <= miss_ovf_d;
`endif
            rd_rsp_vld_q  <= rd_rsp_vld_d;
            rd_rsp_data_q <= rd_rsp_data_d;
            rd_rsp_err_q  <= rd_rsp_err_d;
            dump_vld_q    <= dump_vld_d;
            dump_data_q   <= dump_data_d;
            dump_last_q   <= dump_last_d;
            dump_done_q   <= dump_done_d;
        end
    end

    assign rd_rsp_vld  = rd_rsp_vld_q;
    assign rd_rsp_data = rd_rsp_data_q;
    assign rd_rsp_err  = rd_rsp_err_q;
    assign dump_vld    = dump_vld_q;
    assign dump_data   = dump_data_q;
    assign dump_last   = dump_last_q;
    assign dump_done   = dump_done_q;

endmodule

// File: tb/tb_bjp_stat_rd.sv
// Self-checking bench for bjp_stat_rd: directed vector table, dump/reset sequences,
// a 4-bit-wide instance for the width boundary, and a randomized reference-model run.

module tb_bjp_stat_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        evt_vld, evt_miss, clr, core_end;
    logic [3:0]  evt_cls;
    logic        rd_req_vld, rd_req_rdy, rd_rsp_vld, rd_rsp_rdy, rd_rsp_err;
    logic [4:0]  rd_req_idx;
    logic [31:0] rd_rsp_data;
    logic        dump_vld, dump_rdy, dump_last, dump_done;
    logic [31:0] dump_data;

    // Narrow instance, driven separately, exercises wrap/saturation cheaply.
    logic        w_evt_vld, w_evt_miss, w_clr, w_core_end;
    logic [3:0]  w_evt_cls;
    logic        w_rd_req_vld, w_rd_req_rdy, w_rd_rsp_vld, w_rd_rsp_rdy, w_rd_rsp_err;
    logic [4:0]  w_rd_req_idx;
    logic [3:0]  w_rd_rsp_data;
    logic        w_dump_vld, w_dump_rdy, w_dump_last, w_dump_done;
    logic [3:0]  w_dump_data;

    int cmp_count  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    bjp_stat_rd #(.CNT_W(32), .NUM_CLS(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .evt_vld(evt_vld), .evt_cls(evt_cls), .evt_miss(evt_miss),
        .clr(clr), .core_end(core_end),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_idx(rd_req_idx),
        .rd_rsp_vld(rd_rsp_vld), .rd_rsp_rdy(rd_rsp_rdy),
        .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
        .dump_vld(dump_vld), .dump_rdy(dump_rdy), .dump_data(dump_data),
        .dump_last(dump_last), .dump_done(dump_done)
    );

    bjp_stat_rd #(.CNT_W(4), .NUM_CLS(9)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .evt_vld(w_evt_vld), .evt_cls(w_evt_cls), .evt_miss(w_evt_miss),
        .clr(w_clr), .core_end(w_core_end),
        .rd_req_vld(w_rd_req_vld), .rd_req_rdy(w_rd_req_rdy), .rd_req_idx(w_rd_req_idx),
        .rd_rsp_vld(w_rd_rsp_vld), .rd_rsp_rdy(w_rd_rsp_rdy),
        .rd_rsp_data(w_rd_rsp_data), .rd_rsp_err(w_rd_rsp_err),
        .dump_vld(w_dump_vld), .dump_rdy(w_dump_rdy), .dump_data(w_dump_data),
        .dump_last(w_dump_last), .dump_done(w_dump_done)
    );

    typedef struct {
        logic        evt_vld;
        logic [3:0]  evt_cls;
        logic        evt_miss;
        logic        clr;
        logic [4:0]  rd_idx;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    vec_t        vecs [20];
    logic [31:0] m_tot  [9];
    logic [31:0] m_miss [9];
    rsp_t        exp_q [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        evt_vld  = v.evt_vld;
        evt_cls  = v.evt_cls;
        evt_miss = v.evt_miss;
        clr      = v.clr;
        tick();
        evt_vld  = 1'b0;
        evt_miss = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic doRead(input logic [4:0] idx, output logic [31:0] data, output logic err);
        rd_req_vld = 1'b1;
        rd_req_idx = idx;
        rd_rsp_rdy = 1'b1;
        checkOutput("rd_req_rdy_free", rd_req_rdy, 1);
        tick();
        rd_req_vld = 1'b0;
        checkOutput("rd_rsp_vld_next", rd_rsp_vld, 1);
        data = rd_rsp_data;
        err  = rd_rsp_err;
        tick();
        checkOutput("rd_rsp_vld_drop", rd_rsp_vld, 0);
    endtask

    function automatic rsp_t refRead(input logic [4:0] idx);
        rsp_t r;
        r.data = '0;
        r.err  = 1'b1;
        if (idx < 5'd9) begin
            r.data = m_tot[idx];
            r.err  = 1'b0;
        end else if (idx >= 5'd16 && idx < 5'd25) begin
            r.data = m_miss[idx - 5'd16];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] exp_w [18];
        int          words;
        logic [3:0]  exp4;
        rsp_t        r;

        vecs[0]  = '{1'b1, 4'd12, 1'b1, 1'b0, 5'd0,  32'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'd12, 1'b1, 1'b0, 5'd16, 32'd0, 1'b0};
        vecs[2]  = '{1'b1, 4'd15, 1'b0, 1'b0, 5'd9,  32'd0, 1'b1};
        vecs[3]  = '{1'b1, 4'd12, 1'b1, 1'b0, 5'd30, 32'd0, 1'b1};
        vecs[4]  = '{1'b1, 4'd1,  1'b1, 1'b0, 5'd1,  32'd1, 1'b0};
        vecs[5]  = '{1'b1, 4'd1,  1'b1, 1'b0, 5'd17, 32'd2, 1'b0};
        vecs[6]  = '{1'b1, 4'd1,  1'b0, 1'b0, 5'd1,  32'd3, 1'b0};
        vecs[7]  = '{1'b1, 4'd1,  1'b0, 1'b0, 5'd1,  32'd4, 1'b0};
        vecs[8]  = '{1'b1, 4'd1,  1'b0, 1'b0, 5'd1,  32'd5, 1'b0};
        vecs[9]  = '{1'b1, 4'd8,  1'b0, 1'b0, 5'd8,  32'd1, 1'b0};
        vecs[10] = '{1'b1, 4'd8,  1'b0, 1'b0, 5'd8,  32'd2, 1'b0};
        vecs[11] = '{1'b1, 4'd8,  1'b0, 1'b0, 5'd8,  32'd3, 1'b0};
        vecs[12] = '{1'b0, 4'd0,  1'b0, 1'b0, 5'd24, 32'd0, 1'b0};
        vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 5'd17, 32'd2, 1'b0};
        vecs[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 5'd1,  32'd5, 1'b0};
        vecs[15] = '{1'b1, 4'd2,  1'b0, 1'b1, 5'd2,  32'd0, 1'b0};
        vecs[16] = '{1'b0, 4'd0,  1'b0, 1'b0, 5'd1,  32'd0, 1'b0};
        vecs[17] = '{1'b1, 4'd2,  1'b1, 1'b0, 5'd2,  32'd1, 1'b0};
        vecs[18] = '{1'b0, 4'd0,  1'b0, 1'b0, 5'd18, 32'd1, 1'b0};
        vecs[19] = '{1'b0, 4'd0,  1'b0, 1'b0, 5'd31, 32'd0, 1'b1};

        evt_vld = 0; evt_cls = 0; evt_miss = 0; clr = 0; core_end = 0;
        rd_req_vld = 0; rd_req_idx = 0; rd_rsp_rdy = 0; dump_rdy = 0;
        w_evt_vld = 0; w_evt_cls = 0; w_evt_miss = 0; w_clr = 0; w_core_end = 0;
        w_rd_req_vld = 0; w_rd_req_idx = 0; w_rd_rsp_rdy = 0; w_dump_rdy = 0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_rd_req_rdy", rd_req_rdy, 1);
        checkOutput("rst_rd_rsp_vld", rd_rsp_vld, 0);
        checkOutput("rst_rd_rsp_data", rd_rsp_data, 0);
        checkOutput("rst_rd_rsp_err", rd_rsp_err, 0);
        checkOutput("rst_dump_vld", dump_vld, 0);
        checkOutput("rst_dump_data", dump_data, 0);
        checkOutput("rst_dump_last", dump_last, 0);
        checkOutput("rst_dump_done", dump_done, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] directed vector table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            doRead(vecs[i].rd_idx, d, e);
            checkOutput($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
        end

        $display("[TB] read backpressure");
        for (int i = 0; i < 3; i++) begin
            evt_vld = 1'b1; evt_cls = 4'd0;
            tick();
        end
        evt_vld = 1'b0;
        rd_req_vld = 1'b1; rd_req_idx = 5'd0; rd_rsp_rdy = 1'b0;
        tick();
        rd_req_idx = 5'd5;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp%0d_rsp_vld", i), rd_rsp_vld, 1);
            checkOutput($sformatf("bp%0d_req_rdy", i), rd_req_rdy, 0);
            checkOutput($sformatf("bp%0d_data", i), rd_rsp_data, 3);
            evt_vld = 1'b1; evt_cls = 4'd0;
            tick();
        end
        evt_vld = 1'b0;
        checkOutput("bp_data_final", rd_rsp_data, 3);
        rd_req_vld = 1'b0; rd_rsp_rdy = 1'b1;
        tick();
        checkOutput("bp_rsp_released", rd_rsp_vld, 0);
        doRead(5'd0, d, e);
        checkOutput("bp_b2b_data", d, 7);

        $display("[TB] dump with toggling backpressure");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            evt_vld = 1'b1; evt_cls = 4'd0; evt_miss = (i == 0);
            tick();
        end
        evt_miss = 1'b0;
        core_end = 1'b1;
        tick();
        evt_vld = 1'b0;
        for (int i = 0; i < 18; i++) exp_w[i] = 32'd0;
        exp_w[0] = 32'd7;
        exp_w[9] = 32'd1;
        words = 0;
        for (int cyc = 0; cyc < 100 && words < 18; cyc++) begin
            checkOutput("dump_vld_held", dump_vld, 1);
            dump_rdy = cyc[0];
            evt_vld  = 1'b1;
            evt_cls  = 4'($urandom_range(0, 8));
            evt_miss = 1'b1;
            clr      = (cyc % 5 == 0);
            if (dump_vld && dump_rdy) begin
                checkOutput($sformatf("dump_word%0d", words), dump_data, exp_w[words]);
                checkOutput($sformatf("dump_last%0d", words), dump_last, (words == 17));
                words++;
            end
            tick();
        end
        evt_vld = 1'b0; evt_miss = 1'b0; clr = 1'b0; dump_rdy = 1'b0;
        checkOutput("dump_word_count", words, 18);
        checkOutput("done_dump_vld", dump_vld, 0);
        checkOutput("done_dump_done", dump_done, 1);
        tick();
        checkOutput("done_sticky", dump_done, 1);
        core_end = 1'b0;
        tick();
        checkOutput("idle_dump_done", dump_done, 0);
        doRead(5'd0, d, e);
        checkOutput("post_dump_tot0", d, 7);
        doRead(5'd16, d, e);
        checkOutput("post_dump_miss0", d, 1);
        doRead(5'd3, d, e);
        checkOutput("post_dump_tot3", d, 0);
        doRead(5'd20, d, e);
        checkOutput("post_dump_miss4", d, 0);

        $display("[TB] reset in the middle of a dump");
        core_end = 1'b1;
        tick();
        core_end = 1'b0;
        dump_rdy = 1'b1;
        for (int w = 0; w < 5; w++) begin
            checkOutput($sformatf("rst_dump_vld%0d", w), dump_vld, 1);
            checkOutput($sformatf("rst_dump_word%0d", w), dump_data, exp_w[w]);
            tick();
        end
        checkOutput("dump_not_aborted", dump_vld, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_dump_vld", dump_vld, 0);
        checkOutput("rst_mid_dump_data", dump_data, 0);
        dump_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rst_mid_idle", dump_vld, 0);
        doRead(5'd0, d, e);
        checkOutput("rst_mid_tot0", d, 0);
        doRead(5'd16, d, e);
        checkOutput("rst_mid_miss0", d, 0);

        $display("[TB] width boundary on the 4-bit instance");
`ifdef BJP_STAT_SAT_EN
        exp4 = 4'd15;
`else
        exp4 = 4'd1;
`endif
        for (int i = 0; i < 17; i++) begin
            w_evt_vld = 1'b1; w_evt_cls = 4'd0;
            tick();
        end
        w_evt_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w_rd_req_vld = 1'b1;
            w_rd_req_idx = (k == 0) ? 5'd0 : 5'd16;
            w_rd_rsp_rdy = 1'b1;
            tick();
            w_rd_req_vld = 1'b0;
            checkOutput($sformatf("w4_rsp_vld%0d", k), w_rd_rsp_vld, 1);
            checkOutput($sformatf("w4_data%0d", k), w_rd_rsp_data, (k == 0) ? exp4 : 4'd0);
            tick();
        end

        $display("[TB] randomized run against reference model");
        for (int c = 0; c < 9; c++) begin
            m_tot[c]  = '0;
            m_miss[c] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            evt_vld    = 1'($urandom_range(0, 1));
            evt_cls    = 4'($urandom_range(0, 15));
            evt_miss   = 1'($urandom_range(0, 1));
            clr        = ($urandom_range(0, 31) == 0);
            rd_req_vld = 1'($urandom_range(0, 1));
            rd_req_idx = 5'($urandom_range(0, 31));
            rd_rsp_rdy = ($urandom_range(0, 9) < 6);
            checkOutput("rnd_rsp_vld", rd_rsp_vld, exp_q.size() != 0);
            checkOutput("rnd_req_rdy", rd_req_rdy, exp_q.size() == 0);
            if (rd_rsp_vld && rd_rsp_rdy && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                checkOutput("rnd_rsp_data", rd_rsp_data, r.data);
                checkOutput("rnd_rsp_err", rd_rsp_err, r.err);
            end
            if (rd_req_vld && rd_req_rdy) exp_q.push_back(refRead(rd_req_idx));
            if (clr) begin
                for (int c = 0; c < 9; c++) begin
                    m_tot[c]  = '0;
                    m_miss[c] = '0;
                end
            end else if (evt_vld && evt_cls < 4'd9) begin
                m_tot[evt_cls] = m_tot[evt_cls] + 1;
                if (evt_miss) m_miss[evt_cls] = m_miss[evt_cls] + 1;
            end
            tick();
        end
        evt_vld = 1'b0; evt_miss = 1'b0; clr = 1'b0;
        rd_req_vld = 1'b0; rd_rsp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rd_rsp_vld && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                checkOutput("drain_rsp_data", rd_rsp_data, r.data);
                checkOutput("drain_rsp_err", rd_rsp_err, r.err);
            end
            tick();
        end
        checkOutput("drain_empty", exp_q.size(), 0);
        checkOutput("drain_rsp_vld", rd_rsp_vld, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
